// File: rtl/riscv_pkg.sv
// Shared pipeline types for the IF stage.
// Holds the PC sequencer state encoding and default increment.
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_HALT
  } pc_state_t;

  localparam int PC_INC_DEFAULT = 4;

endpackage

// File: rtl/pc_redirect_buffer.sv
// Single-entry store for a redirect that arrives while fetch cannot advance.
// The newest load overwrites; consume or clear empties it.
module pc_redirect_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            consume,
  input  logic            clear,
  output logic [XLEN-1:0] pending_pc,
  output logic            pending_v
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_v  <= 1'b0;
      pending_pc <= '0;
    end else if (consume || clear) begin
      pending_v  <= 1'b0;
    end else if (load) begin
      pending_v  <= 1'b1;
      pending_pc <= load_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage program counter: boot/run/halt FSM, redirect buffering, epoch tag.
// Optional trap redirect is built only when PC_TRAP_EN is defined.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = PC_INC_DEFAULT,
  parameter int              EPOCH_W      = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               trap_valid,
  output logic [XLEN-1:0]    pc,
  output logic               pc_valid,
  output logic [EPOCH_W-1:0] epoch,
  output logic               pc_misaligned,
  output logic [XLEN-1:0]    epc
);

  localparam logic [XLEN-1:0] INC_X = XLEN'(INC);

  pc_state_t state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic            bump;
  logic            buf_load;
  logic            buf_consume;
  logic            buf_clear;
  logic [XLEN-1:0] pending_pc;
  logic            pending_v;

  pc_redirect_buffer #(
    .XLEN(XLEN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_pc   (redirect_pc),
    .consume   (buf_consume),
    .clear     (buf_clear),
    .pending_pc(pending_pc),
    .pending_v (pending_v)
  );

`ifdef PC_TRAP_EN
  logic [XLEN-1:0] epc_d;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    bump        = 1'b0;
    buf_load    = 1'b0;
    buf_consume = 1'b0;
    buf_clear   = 1'b0;
`ifdef PC_TRAP_EN
    epc_d       = epc;
`endif
    unique case (1'b1)
      state_q == PC_BOOT: begin
        state_d  = PC_RUN;
        buf_load = redirect_valid;
      end
      state_q == PC_RUN: begin
        // a halting cycle still takes a redirect but holds otherwise
        if (pc_write && redirect_valid) begin
          pc_d        = redirect_pc;
          bump        = 1'b1;
          buf_consume = 1'b1;
        end else if (pc_write && !halt_req && pending_v) begin
          pc_d        = pending_pc;
          bump        = 1'b1;
          buf_consume = 1'b1;
        end else if (pc_write && !halt_req) begin
          pc_d = pc + INC_X;
        end else if (!pc_write) begin
          buf_load = redirect_valid;
        end
        if (halt_req) state_d = PC_HALT;
      end
      state_q == PC_HALT: begin
        if (resume) begin
          state_d = PC_RUN;
          if (redirect_valid) begin
            pc_d        = redirect_pc;
            bump        = 1'b1;
            buf_consume = 1'b1;
          end else if (pending_v) begin
            pc_d        = pending_pc;
            bump        = 1'b1;
            buf_consume = 1'b1;
          end
        end else begin
          buf_load = redirect_valid;
        end
      end
      default: state_d = PC_BOOT;
    endcase
`ifdef PC_TRAP_EN
    if (trap_valid && state_q != PC_BOOT) begin
      state_d     = PC_RUN;
      pc_d        = TRAP_VECTOR;
      epc_d       = pc;
      bump        = 1'b1;
      buf_load    = 1'b0;
      buf_consume = 1'b0;
      buf_clear   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PC_BOOT;
      pc      <= RESET_VECTOR;
      epoch   <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      if (bump) epoch <= epoch + 1'b1;
    end
  end

`ifdef PC_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst) epc <= '0;
    else      epc <= epc_d;
  end
`else
  logic            unused_trap;
  logic [XLEN-1:0] unused_tvec;
  assign unused_trap = trap_valid;
  assign unused_tvec = TRAP_VECTOR;
  assign epc         = '0;
`endif

  assign pc_valid      = (state_q == PC_RUN);
  assign pc_misaligned = |pc[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios, then random traffic.
// Define PC_TRAP_EN for both DUT and bench to exercise the trap path.
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [1:0]  ep;
    logic        mis;
    logic [31:0] epc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] pc;
  logic        pc_valid;
  logic [1:0]  epoch;
  logic        pc_misaligned;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // reference: mode 0=booting, 1=fetching, 2=halted
  int          m_mode;
  logic [31:0] m_pc;
  int          m_epoch;
  logic [31:0] m_epc;
  logic [31:0] m_pend[$];

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .resume        (resume),
    .trap_valid    (trap_valid),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .epoch         (epoch),
    .pc_misaligned (pc_misaligned),
    .epc           (epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, req);
    end
  endtask

  function automatic void jump(input logic [31:0] t);
    m_pc    = t;
    m_epoch = (m_epoch + 1) % 4;
    m_pend.delete();
  endfunction

  function automatic void stash(input logic [31:0] t);
    m_pend.delete();
    m_pend.push_back(t);
  endfunction

  function automatic void model(input logic r, pw, rv,
                                input logic [31:0] rpc,
                                input logic hr, res, tv);
    bit trap;
    trap = 1'b0;
`ifdef PC_TRAP_EN
    trap = tv && (m_mode != 0);
`endif
    if (!r) begin
      m_mode = 0; m_pc = 32'h0; m_epoch = 0; m_epc = 32'h0;
      m_pend.delete();
    end else if (trap) begin
      m_epc = m_pc;
      jump(32'h100);
      m_mode = 1;
    end else if (m_mode == 0) begin
      if (rv) stash(rpc);
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (pw && rv) jump(rpc);
      else if (pw && !hr && m_pend.size() > 0) jump(m_pend[0]);
      else if (pw && !hr) m_pc = m_pc + 32'd4;
      else if (!pw && rv) stash(rpc);
      if (hr) m_mode = 2;
    end else begin
      if (res) begin
        if (rv) jump(rpc);
        else if (m_pend.size() > 0) jump(m_pend[0]);
        m_mode = 1;
      end else if (rv) begin
        stash(rpc);
      end
    end
  endfunction

  task automatic step(input logic r, pw, rv, input logic [31:0] rpc,
                      input logic hr, res, tv);
    exp_t e;
    @(negedge clk);
    rst = r; pc_write = pw; redirect_valid = rv; redirect_pc = rpc;
    halt_req = hr; resume = res; trap_valid = tv;
    model(r, pw, rv, rpc, hr, res, tv);
    e.pc  = m_pc;
    e.v   = (m_mode == 1);
    e.ep  = 2'(m_epoch);
    e.mis = (m_pc[1:0] != 2'b00);
    e.epc = m_epc;
    exp_q.push_back(e);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_valid", 32'(pc_valid), 32'(e.v));
        chk("epoch", 32'(epoch), 32'(e.ep));
        chk("misaligned", 32'(pc_misaligned), 32'(e.mis));
        chk("epc", epc, e.epc);
      end
    end
  end

  initial begin : stim
    logic [31:0] t;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    adv(4);
    // stall with one redirect in the middle
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h40, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    adv(2);
    // two redirects in one stall: newest wins
    step(1, 0, 1, 32'h80, 0, 0, 0);
    step(1, 0, 1, 32'h90, 0, 0, 0);
    adv(2);
    // halt then resume
    step(1, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    adv(2);
    // redirect and halt in the same cycle
    step(1, 1, 1, 32'h200, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    adv(1);
    // misaligned target
    step(1, 1, 1, 32'h102, 0, 0, 0);
    adv(2);
    // trap during a stall holding a pending redirect
    step(1, 1, 1, 32'h20, 0, 0, 0);
    step(1, 0, 1, 32'h300, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    adv(2);
    // address wrap
    step(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    adv(2);
    // reset while halted with a pending redirect
    step(1, 1, 0, 0, 1, 0, 0);
    step(1, 0, 1, 32'h500, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    adv(3);
    for (int i = 0; i < 600; i++) begin
      t = $urandom();
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step($urandom_range(0, 63) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 6) == 0, t,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
